// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings and framing constants,
// common to the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [4:0] {
        STATE_IDLE      = 5'b00001,
        STATE_START     = 5'b00010,
        STATE_DATA      = 5'b00100,
        STATE_STOP      = 5'b01000,
        STATE_WAIT_IDLE = 5'b10000
    } state_t;

    localparam logic [15:0] DEFAULT_CLOCK_DIV = 16'd217;
    localparam int          UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-consumer bundle. Handshake: rx_data is stable while rx_valid=1; a byte is
// accepted on a rising clock edge where rx_valid & rx_ack; rx_ack without rx_valid is ignored.
interface uart_receiver_if #(
    parameter int DIV_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] clock_div;
    logic                 rx;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_error;
    logic                 overrun;
    logic                 err_clear;
    logic                 busy;
    logic [4:0]           state_dbg;

    modport slave (
        input  clock_div, rx, rx_ack, err_clear,
        output rx_data, rx_valid, frame_error, overrun, busy, state_dbg
    );

    modport master (
        output clock_div, rx, rx_ack, err_clear,
        input  rx_data, rx_valid, frame_error, overrun, busy, state_dbg
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin. Flops preset to 1 so that
// reset release never looks like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised rx line, one-hot framing FSM, LSB-first shift register
// and a valid/ack output stage with sticky frame-error and overrun flags.
module uart_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_WIDTH   = 16
) (
    input  logic            clock,
    input  logic            reset,
    uart_receiver_if.slave  bus
);
    import uart_pkg::*;

    logic                 w_rx_s;
    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_error;
    logic                 r_overrun;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock  (clock),
        .reset  (reset),
        .i_rx   (bus.rx),
        .o_rx_s (w_rx_s)
    );

    logic w_mid_start, w_bit_end, w_stop_sample, w_stop_good;
    logic w_can_load, w_deliver, w_overrun_set, w_frame_set;

    assign w_mid_start   = (r_cnt == (r_div >> 1));
    assign w_bit_end     = (r_cnt == (r_div - DIV_WIDTH'(1)));
    assign w_stop_sample = (r_state == STATE_STOP) && w_bit_end;
    assign w_stop_good   = w_stop_sample && w_rx_s;
    // An ack on the delivery edge frees the holding register for the new byte.
    assign w_can_load    = !r_rx_valid || bus.rx_ack;
    assign w_deliver     = w_stop_good && w_can_load;
    assign w_overrun_set = w_stop_good && !w_can_load;
    assign w_frame_set   = w_stop_sample && !w_rx_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= STATE_IDLE;
            r_div         <= '0;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            case (r_state)
                STATE_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_div   <= bus.clock_div;
                        r_state <= STATE_START;
                    end
                end
                STATE_START: begin
                    if (w_mid_start) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= w_rx_s ? STATE_IDLE : STATE_DATA;
                    end
                end
                STATE_DATA: begin
                    if (w_bit_end) begin
                        r_shift[r_bit] <= w_rx_s;
                        r_cnt          <= '0;
                        r_bit          <= r_bit + 3'd1;
                        if (r_bit == 3'(UART_DATA_BITS - 1)) r_state <= STATE_STOP;
                    end
                end
                STATE_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? STATE_IDLE : STATE_WAIT_IDLE;
                    end
                end
                STATE_WAIT_IDLE: begin
                    if (w_rx_s) r_state <= STATE_IDLE;
                end
                default: r_state <= STATE_IDLE;
            endcase

            if (w_deliver) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (bus.rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
            end

            // Set events take priority over a simultaneous clear.
            if (w_frame_set)        r_frame_error <= 1'b1;
            else if (bus.err_clear) r_frame_error <= 1'b0;
            if (w_overrun_set)      r_overrun <= 1'b1;
            else if (bus.err_clear) r_overrun <= 1'b0;
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = (r_state != STATE_IDLE);
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: normal bytes, glitch rejection, framing error,
// overrun, mid-frame reset and minimum clock_div back-to-back traffic.
module tb_uart_receiver;
    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_STOP = 5'b01000;
    localparam logic [4:0] S_WAIT = 5'b10000;

    uart_receiver_if #(.DIV_WIDTH(16)) bus ();

    uart_receiver #(.SYNC_STAGES(2), .DIV_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not produced");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input int div);
        bus.rx = b;
        tick(div);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int div);
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(d[i], div);
        send_bit(stop, div);
    endtask

    task automatic pulse_ack();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        tick(1);
        bus.err_clear = 1'b0;
    endtask

    task automatic wait_state(input logic [4:0] s, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.state_dbg === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic ok;
        reset         = 1'b1;
        bus.rx        = 1'b1;
        bus.rx_ack    = 1'b0;
        bus.err_clear = 1'b0;
        bus.clock_div = 16'd217;
        tick(3);
        reset = 1'b0;
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_frame_error", bus.frame_error, 1'b0);
        check("reset_overrun", bus.overrun, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_state", bus.state_dbg, S_IDLE);
        tick(5);

        // 1: two normal bytes, acked
        send_byte(8'h55, 1'b1, 217);
        check("t1_valid_55", bus.rx_valid, 1'b1);
        check("t1_data_55", bus.rx_data, 8'h55);
        pulse_ack();
        check("t1_valid_cleared_55", bus.rx_valid, 1'b0);
        send_byte(8'hA3, 1'b1, 217);
        check("t1_valid_a3", bus.rx_valid, 1'b1);
        check("t1_data_a3", bus.rx_data, 8'hA3);
        pulse_ack();
        check("t1_valid_cleared_a3", bus.rx_valid, 1'b0);
        check("t1_frame_error", bus.frame_error, 1'b0);
        check("t1_overrun", bus.overrun, 1'b0);

        // 2: short low glitch
        bus.rx = 1'b0;
        tick(50);
        check("t2_busy_in_glitch", bus.busy, 1'b1);
        bus.rx = 1'b1;
        tick(150);
        check("t2_busy_after", bus.busy, 1'b0);
        check("t2_state_idle", bus.state_dbg, S_IDLE);
        check("t2_valid", bus.rx_valid, 1'b0);

        // 3: framing error then held-low line
        send_byte(8'h3C, 1'b0, 217);
        tick(1000);
        check("t3_frame_error", bus.frame_error, 1'b1);
        check("t3_valid", bus.rx_valid, 1'b0);
        check("t3_state_wait", bus.state_dbg, S_WAIT);
        bus.rx = 1'b1;
        tick(5);
        check("t3_state_idle", bus.state_dbg, S_IDLE);
        check("t3_fe_sticky", bus.frame_error, 1'b1);
        pulse_clear();
        check("t3_fe_cleared", bus.frame_error, 1'b0);
        send_byte(8'h3C, 1'b1, 217);
        check("t3_valid_ok", bus.rx_valid, 1'b1);
        check("t3_data_ok", bus.rx_data, 8'h3C);
        check("t3_fe_ok", bus.frame_error, 1'b0);
        pulse_ack();

        // 4a: overrun
        send_byte(8'h11, 1'b1, 217);
        send_byte(8'h22, 1'b1, 217);
        check("t4_data_kept", bus.rx_data, 8'h11);
        check("t4_valid_kept", bus.rx_valid, 1'b1);
        check("t4_overrun", bus.overrun, 1'b1);
        pulse_ack();
        check("t4_valid_cleared", bus.rx_valid, 1'b0);
        pulse_clear();
        check("t4_overrun_cleared", bus.overrun, 1'b0);

        // 4b: ack lands on the delivery edge of the second byte
        send_byte(8'h11, 1'b1, 217);
        check("t4b_data_11", bus.rx_data, 8'h11);
        fork
            send_byte(8'h22, 1'b1, 217);
            begin
                wait_state(S_STOP, 3000, ok);
                check("t4b_reached_stop", ok, 1'b1);
                tick(216);
                bus.rx_ack = 1'b1;
                tick(1);
                bus.rx_ack = 1'b0;
            end
        join
        check("t4b_data_22", bus.rx_data, 8'h22);
        check("t4b_valid", bus.rx_valid, 1'b1);
        check("t4b_overrun", bus.overrun, 1'b0);
        pulse_ack();

        // 5: reset during bit 4 of 0xF0, with an unaccepted byte pending
        send_byte(8'h5A, 1'b1, 217);
        check("t5_pending", bus.rx_valid, 1'b1);
        send_bit(1'b0, 217);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 217);
        bus.rx = 1'b1;
        tick(108);
        check("t5_busy_mid", bus.busy, 1'b1);
        reset = 1'b1;
        tick(1);
        check("t5_rst_data", bus.rx_data, 8'h00);
        check("t5_rst_valid", bus.rx_valid, 1'b0);
        check("t5_rst_busy", bus.busy, 1'b0);
        check("t5_rst_state", bus.state_dbg, S_IDLE);
        reset = 1'b0;
        tick(3 * 217);
        send_byte(8'h0F, 1'b1, 217);
        check("t5_valid_0f", bus.rx_valid, 1'b1);
        check("t5_data_0f", bus.rx_data, 8'h0F);
        check("t5_fe", bus.frame_error, 1'b0);
        pulse_ack();

        // 6: minimum divider, back-to-back bytes
        bus.clock_div = 16'd4;
        tick(5);
        exp_q = '{8'h00, 8'hFF, 8'h81};
        fork
            begin
                send_byte(8'h00, 1'b1, 4);
                send_byte(8'hFF, 1'b1, 4);
                send_byte(8'h81, 1'b1, 4);
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clock);
                    if (bus.rx_ack) bus.rx_ack = 1'b0;
                    else if (bus.rx_valid) begin
                        got_q.push_back(bus.rx_data);
                        bus.rx_ack = 1'b1;
                    end
                end
                bus.rx_ack = 1'b0;
            end
        join
        check("t6_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("t6_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        check("t6_overrun", bus.overrun, 1'b0);
        check("t6_frame_error", bus.frame_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
